spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk rising edge).
REQ-003 cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-004 sck  input  1  SPI serial clock, mode 0 (idle low), asynchronous to clk.
REQ-005 mosi  input  1  serial data in, MSB first.
REQ-006 miso  output  1  serial data out, MSB first; 0 when not shifting read data.
REQ-007 reg_addr  output  8  register address captured from frame.
REQ-008 reg_wdata  output  8  write data captured from frame.
REQ-009 reg_we  output  1  one-clk write strobe.
REQ-010 reg_re  output  1  one-clk read strobe.
REQ-011 reg_rdata  input  8  read data, valid the clk after reg_re.
REQ-012 busy  output  1  high while a frame is in progress (cs low).
REQ-013 frame_done  output  1  one-clk pulse: complete 24-bit frame received.
REQ-014 frame_err  output  1  one-clk pulse: cs deasserted mid-frame.

Function
REQ-015 Frame = 8-bit command, 8-bit address, 8-bit data, MSB first, 24 sck rising edges while cs low.
REQ-016 cs, sck, mosi pass through 2-flop synchronizers; sck edges detected from synchronized samples.
REQ-017 mosi sampled on synchronized sck rising edge; miso updated on synchronized sck falling edge.
REQ-018 sck high and low phases each >= 4 clk periods; faster sck is out of contract.
REQ-019 States: IDLE, CMD, ADDR, DATA, DONE.
REQ-020 IDLE -> CMD on synchronized cs falling; bit counter cleared to 0.
REQ-021 CMD -> ADDR after 8th rising edge; command bit 7: 1 = read, 0 = write; bits 6:0 ignored.
REQ-022 ADDR -> DATA after 16th rising edge; reg_addr updated same clk.
REQ-023 Read: reg_re pulses the clk after address completes; reg_rdata loaded into shift register next clk.
REQ-024 Read: miso = rdata bit 7 from first sck falling edge after bit 16; then bits 6..0 on subsequent falling edges.
REQ-025 Write: after 24th rising edge, reg_wdata updated and reg_we pulses exactly once, following clk.
REQ-026 Read: mosi bits in DATA phase shifted but discarded; no reg_we.
REQ-027 DATA -> DONE after 24th rising edge; frame_done pulses once on entry to DONE.
REQ-028 DONE: further sck edges ignored, miso = 0; DONE -> IDLE on synchronized cs rising.
REQ-029 cs rising in CMD/ADDR/DATA: frame_err pulse, no reg_we, miso = 0, -> IDLE.
REQ-030 reg_re already issued before abort is not retracted; no second reg_re.
REQ-031 sck edges while cs high ignored; busy = synchronized cs inverted.
REQ-032 Bit counter 5 bits, saturates at 24; no wrap.

Reset
REQ-033 rst=0: state IDLE, counter 0, shift registers 0, miso 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, busy 0, frame_done 0, frame_err 0.
REQ-034 Synchronizer flops reset to idle levels: cs 1, sck 0, mosi 0.
REQ-035 Reset mid-frame: abandon frame, no strobes; after release, wait for a fresh cs falling edge.

Structure
REQ-036 Shared package spi_pkg: FRAME_BITS=24, BYTE_W=8, CMD_READ_BIT=7, state enumeration.
REQ-037 One sub-module spi_sync: 2-flop synchronizer with rise/fall pulse outputs, instantiated for cs and sck; mosi uses synchronizer only.

Verification
REQ-038 Write cmd 0x00, addr 0x34, data 0xCB -> one reg_we, reg_addr=0x34, reg_wdata=0xCB, one frame_done, miso 0 throughout.
REQ-039 Read cmd 0xFF, addr 0x67, reg_rdata=0x98 -> one reg_re, reg_addr=0x67, miso bits 1,0,0,1,1,0,0,0, no reg_we.
REQ-040 cmd 0xA5 (read), addr 0x12, cs raised after 12 bits -> frame_err pulse, no reg_re/reg_we/frame_done.
REQ-041 rst=0 during bit 18 of write frame -> all outputs reset values, no reg_we; next full frame accepted normally.
REQ-042 Write frame followed by 4 extra sck pulses before cs rises -> single reg_we, single frame_done.
REQ-043 Back-to-back frames, cs high for 4 clk -> both frames decoded correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI register-access slave.
package spi_pkg;

  localparam int unsigned FRAME_BITS   = 24;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned CMD_READ_BIT = 7;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StCmd  = 3'd1;
  localparam state_t StAddr = 3'd2;
  localparam state_t StData = 3'd3;
  localparam state_t StDone = 3'd4;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with single-cycle rise/fall pulses from the synchronized level.
module spi_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave decoding 24-bit command/address/data frames into register strobes.
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [4:0] CntCmd   = 5'(BYTE_W);
  localparam logic [4:0] CntAddr  = 5'(2 * BYTE_W);
  localparam logic [4:0] CntFrame = 5'(FRAME_BITS);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;

  spi_sync #(.ResetVal(1'b1)) u_cs_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (cs),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync #(.ResetVal(1'b0)) u_sck_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (sck),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  logic mosi_meta_q, mosi_q;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d, cnt_next;
  logic [BYTE_W-1:0] shift_q, shift_d, shift_next;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              read_q, read_d;
  logic              miso_q, miso_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              load_q, load_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        flush_q, flush_d;
  logic              armed_q, armed_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    read_d       = read_q;
    miso_d       = miso_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    load_d       = reg_re_q;
    shift_next   = {shift_q[BYTE_W-2:0], mosi_q};
    cnt_next     = (cnt_q == CntFrame) ? cnt_q : cnt_q + 5'd1;

    // Only trust a cs falling edge once the synchronizer holds real pin samples that were high,
    // so a reset released mid-frame waits for a fresh frame.
    flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    armed_d = armed_q | ((flush_q == 2'd2) & cs_s);

    if (load_q) tx_d = reg_rdata;

    case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        // Mode 0: sck must idle low when the frame opens.
        if (cs_fall && armed_q && !sck_s) begin
          state_d = StCmd;
          cnt_d   = '0;
          shift_d = '0;
          read_d  = 1'b0;
        end
      end
      StCmd, StAddr, StData: begin
        if (cs_rise) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else begin
          if (sck_rise) begin
            shift_d = shift_next;
            cnt_d   = cnt_next;
            if (cnt_next == CntCmd) begin
              read_d  = shift_next[CMD_READ_BIT];
              state_d = StAddr;
            end else if (cnt_next == CntAddr) begin
              reg_addr_d = shift_next;
              reg_re_d   = read_q;
              state_d    = StData;
            end else if (cnt_next == CntFrame) begin
              state_d      = StDone;
              frame_done_d = 1'b1;
              miso_d       = 1'b0;
              if (!read_q) begin
                reg_wdata_d = shift_next;
                reg_we_d    = 1'b1;
              end
            end
          end
          if (sck_fall && (state_q == StData) && read_q) begin
            miso_d = tx_q[BYTE_W-1];
            tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mosi_meta_q  <= 1'b0;
      mosi_q       <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      read_q       <= 1'b0;
      miso_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      load_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      flush_q      <= '0;
      armed_q      <= 1'b0;
    end else begin
      mosi_meta_q  <= mosi;
      mosi_q       <= mosi_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      read_q       <= read_d;
      miso_q       <= miso_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      load_q       <= load_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
    end
  end

  assign miso       = miso_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;
  assign busy       = ~cs_s;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
